// File: rtl/filtros_pkg.sv
// Shared defaults and helpers for the row-filter datapath blocks.
package filtros_pkg;

  localparam int BITS_DATOS_DEF = 8;
  localparam int NUM_FILAS_DEF  = 3;

  typedef enum logic {
    MODO_ROTATIVO = 1'b0,
    MODO_FIJO     = 1'b1
  } modo_e;

  // Ceiling log2, never below 1 so a select field always has at least one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_rotacion_filas_if.sv
// Row-word bus between a row source and the row rotation mux.
interface mux_rotacion_filas_if
  import filtros_pkg::*;
#(
  parameter int BITS_DATOS = BITS_DATOS_DEF,
  parameter int NUM_FILAS  = NUM_FILAS_DEF,
  parameter int SEL_BITS   = clog2_min1(NUM_FILAS)
);

  logic [NUM_FILAS*BITS_DATOS-1:0] entradas;
  logic                            valido_entrada;
  logic                            fin_fila;
  logic                            modo_fijo;
  logic [SEL_BITS-1:0]             desplazamiento_fijo;
  logic [NUM_FILAS*BITS_DATOS-1:0] salidas;
  logic                            valido_salida;
  logic [SEL_BITS-1:0]             desplazamiento;

  modport master (
    output entradas, valido_entrada, fin_fila, modo_fijo, desplazamiento_fijo,
    input  salidas, valido_salida, desplazamiento
  );

  modport slave (
    input  entradas, valido_entrada, fin_fila, modo_fijo, desplazamiento_fijo,
    output salidas, valido_salida, desplazamiento
  );

endinterface

// File: rtl/contador_modulo.sv
// Wrap-around counter 0..MODULO-1, advancing one step per enabled cycle.
module contador_modulo
  import filtros_pkg::*;
#(
  parameter int MODULO = NUM_FILAS_DEF,
  parameter int ANCHO  = clog2_min1(MODULO)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             habilitar,
  output logic [ANCHO-1:0] cuenta
);

  localparam logic [ANCHO-1:0] ULTIMO = ANCHO'(MODULO - 1);

  logic [ANCHO-1:0] cuenta_q, cuenta_d;

  always_comb begin
    cuenta_d = cuenta_q;
    if (habilitar) begin
      cuenta_d = (cuenta_q == ULTIMO) ? '0 : cuenta_q + ANCHO'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cuenta_q <= '0;
    else       cuenta_q <= cuenta_d;
  end

  assign cuenta = cuenta_q;

endmodule

// File: rtl/mux_rotacion_filas.sv
// Rotates the packed row channels by a fixed or end-of-row-advancing offset,
// registering the result in a single output bank.
module mux_rotacion_filas
  import filtros_pkg::*;
#(
  parameter int BITS_DATOS = BITS_DATOS_DEF,
  parameter int NUM_FILAS  = NUM_FILAS_DEF,
  parameter int SEL_BITS   = clog2_min1(NUM_FILAS)
) (
  input logic                  clk,
  input logic                  reset,
  mux_rotacion_filas_if.slave  bus
);

  localparam int ANCHO_BUS = NUM_FILAS * BITS_DATOS;
  // One extra bit so the limit is representable when NUM_FILAS is a power of two.
  localparam logic [SEL_BITS:0] LIMITE = (SEL_BITS + 1)'(NUM_FILAS);

  logic [SEL_BITS-1:0]  cuenta;
  logic [SEL_BITS-1:0]  desp_efectivo;
  logic                 avanzar;
  logic [ANCHO_BUS-1:0] datos_p1_q, datos_p1_d;
  logic                 vld_p1_q, vld_p1_d;

  function automatic logic [SEL_BITS-1:0] sanear(input logic [SEL_BITS-1:0] d);
    return ({1'b0, d} >= LIMITE) ? '0 : d;
  endfunction

  function automatic logic [ANCHO_BUS-1:0] rotar(input logic [ANCHO_BUS-1:0] e,
                                                 input logic [SEL_BITS-1:0]  s);
    logic [ANCHO_BUS-1:0] r;
    int idx;
    r = '0;
    for (int k = 0; k < NUM_FILAS; k++) begin
      idx = k + int'(s);
      if (idx >= NUM_FILAS) idx = idx - NUM_FILAS;
      r[k*BITS_DATOS +: BITS_DATOS] = e[idx*BITS_DATOS +: BITS_DATOS];
    end
    return r;
  endfunction

  // Fixed mode freezes the rotating offset so rotation resumes where it stopped.
  assign avanzar = bus.fin_fila && (modo_e'(bus.modo_fijo) == MODO_ROTATIVO);

  contador_modulo #(
    .MODULO (NUM_FILAS),
    .ANCHO  (SEL_BITS)
  ) u_contador (
    .clk       (clk),
    .reset     (reset),
    .habilitar (avanzar),
    .cuenta    (cuenta)
  );

  always_comb begin
    desp_efectivo = cuenta;
    if (modo_e'(bus.modo_fijo) == MODO_FIJO) desp_efectivo = sanear(bus.desplazamiento_fijo);
  end

  always_comb begin
    datos_p1_d = datos_p1_q;
    vld_p1_d   = bus.valido_entrada;
    if (bus.valido_entrada) datos_p1_d = rotar(bus.entradas, desp_efectivo);
  end

  // p0 -> p1: rotated words and their valid flag
  always_ff @(posedge clk) begin
    if (reset) begin
      datos_p1_q <= '0;
      vld_p1_q   <= 1'b0;
    end else begin
      datos_p1_q <= datos_p1_d;
      vld_p1_q   <= vld_p1_d;
    end
  end

  assign bus.salidas        = datos_p1_q;
  assign bus.valido_salida  = vld_p1_q;
  assign bus.desplazamiento = cuenta;

endmodule

// File: tb/tb_mux_rotacion_filas.sv
// Directed-vector bench for mux_rotacion_filas with three 8-bit row channels.
module tb_mux_rotacion_filas;

  localparam logic [23:0] D  = 24'h332211;
  localparam logic [23:0] R1 = 24'h113322;
  localparam logic [23:0] R2 = 24'h221133;

  typedef struct {
    logic [23:0] ent;
    logic        v;
    logic        f;
    logic        m;
    logic [1:0]  fijo;
    logic [23:0] sal;
    logic        vs;
    logic [1:0]  desp;
  } vec_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  vec_t tabla [19];

  mux_rotacion_filas_if #(.BITS_DATOS(8), .NUM_FILAS(3), .SEL_BITS(2)) bus ();

  mux_rotacion_filas #(.BITS_DATOS(8), .NUM_FILAS(3), .SEL_BITS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nombre, input logic [31:0] obtenido, input logic [31:0] esperado);
    tests++;
    if (obtenido !== esperado) begin
      fails++;
      $display("FAIL %s: obtenido %0h esperado %0h", nombre, obtenido, esperado);
    end
  endtask

  task automatic conducir(input logic [23:0] ent, input logic v, input logic f,
                          input logic m, input logic [1:0] fijo, input logic rst);
    bus.entradas            = ent;
    bus.valido_entrada      = v;
    bus.fin_fila            = f;
    bus.modo_fijo           = m;
    bus.desplazamiento_fijo = fijo;
    reset                   = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_salidas(input string n, input logic [23:0] sal, input logic vs, input logic [1:0] desp);
    chk({n, "_salidas"}, {8'h00, bus.salidas}, {8'h00, sal});
    chk({n, "_valido"}, {31'd0, bus.valido_salida}, {31'd0, vs});
    chk({n, "_desp"}, {30'd0, bus.desplazamiento}, {30'd0, desp});
  endtask

  initial begin
    tests = 0;
    fails = 0;

    tabla[0]  = '{D,            1'b1, 1'b0, 1'b0, 2'd0, D,            1'b1, 2'd0};
    tabla[1]  = '{D,            1'b0, 1'b1, 1'b0, 2'd0, D,            1'b0, 2'd1};
    tabla[2]  = '{D,            1'b1, 1'b0, 1'b0, 2'd0, R1,           1'b1, 2'd1};
    tabla[3]  = '{D,            1'b0, 1'b1, 1'b0, 2'd0, R1,           1'b0, 2'd2};
    tabla[4]  = '{D,            1'b1, 1'b0, 1'b0, 2'd0, R2,           1'b1, 2'd2};
    tabla[5]  = '{D,            1'b0, 1'b1, 1'b0, 2'd0, R2,           1'b0, 2'd0};
    tabla[6]  = '{D,            1'b1, 1'b0, 1'b0, 2'd0, D,            1'b1, 2'd0};
    tabla[7]  = '{D,            1'b1, 1'b1, 1'b0, 2'd0, D,            1'b1, 2'd1};
    tabla[8]  = '{D,            1'b1, 1'b0, 1'b0, 2'd0, R1,           1'b1, 2'd1};
    tabla[9]  = '{D,            1'b1, 1'b1, 1'b1, 2'd2, R2,           1'b1, 2'd1};
    tabla[10] = '{D,            1'b1, 1'b1, 1'b1, 2'd2, R2,           1'b1, 2'd1};
    tabla[11] = '{D,            1'b1, 1'b0, 1'b1, 2'd3, D,            1'b1, 2'd1};
    tabla[12] = '{D,            1'b1, 1'b0, 1'b0, 2'd0, R1,           1'b1, 2'd1};
    tabla[13] = '{24'hAABBCC,   1'b0, 1'b0, 1'b0, 2'd0, R1,           1'b0, 2'd1};
    tabla[14] = '{24'h010203,   1'b0, 1'b0, 1'b0, 2'd0, R1,           1'b0, 2'd1};
    tabla[15] = '{24'hFFFFFF,   1'b0, 1'b0, 1'b0, 2'd0, R1,           1'b0, 2'd1};
    tabla[16] = '{24'h000000,   1'b0, 1'b0, 1'b0, 2'd0, R1,           1'b0, 2'd1};
    tabla[17] = '{24'hCCBBAA,   1'b1, 1'b0, 1'b0, 2'd0, 24'hAACCBB,   1'b1, 2'd1};
    tabla[18] = '{D,            1'b0, 1'b1, 1'b0, 2'd0, 24'hAACCBB,   1'b0, 2'd2};

    reset                   = 1'b1;
    bus.entradas            = '0;
    bus.valido_entrada      = 1'b0;
    bus.fin_fila            = 1'b0;
    bus.modo_fijo           = 1'b0;
    bus.desplazamiento_fijo = '0;

    // Reset with junk inputs present: everything must come up cleared.
    conducir(D, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
    conducir(D, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
    chk_salidas("reset_inicial", 24'h0, 1'b0, 2'd0);

    for (int i = 0; i < 19; i++) begin
      conducir(tabla[i].ent, tabla[i].v, tabla[i].f, tabla[i].m, tabla[i].fijo, 1'b0);
      chk_salidas($sformatf("vec%0d", i), tabla[i].sal, tabla[i].vs, tabla[i].desp);
    end

    // Offset is now 2; reset lands together with a valid word and an end-of-row pulse.
    conducir(D, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
    chk_salidas("reset_en_vuelo", 24'h0, 1'b0, 2'd0);

    conducir(D, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    chk_salidas("tras_reset", D, 1'b1, 2'd0);

    // Fixed offset 1 while the rotating offset stays at 0.
    conducir(D, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
    chk_salidas("fijo_1", R1, 1'b1, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_rotacion_filas.md
MUX_ROTACION_FILAS -- requirements
Module: mux_rotacion_filas

Interface
REQ-001 SHALL have parameter BITS_DATOS, default 8, width of one pixel/data word.
REQ-002 SHALL have parameter NUM_FILAS, default 3, number of row channels, legal range 2..8.
REQ-003 SHALL have parameter SEL_BITS, default clog2(NUM_FILAS) (min 1), width of offset fields.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 entradas  input  NUM_FILAS*BITS_DATOS  packed row words; channel i at bits [i*BITS_DATOS +: BITS_DATOS].
REQ-008 valido_entrada  input  1  entradas valid this cycle.
REQ-009 fin_fila  input  1  single-cycle end-of-row pulse; advances rotation.
REQ-010 modo_fijo  input  1  1 = use desplazamiento_fijo, 0 = use internal rotating offset.
REQ-011 desplazamiento_fijo  input  SEL_BITS  static offset used when modo_fijo=1.
REQ-012 salidas  output  NUM_FILAS*BITS_DATOS  rotated row words, same packing as entradas.
REQ-013 valido_salida  output  1  salidas updated with valid data.
REQ-014 desplazamiento  output  SEL_BITS  current internal rotating offset.

Function
REQ-015 Internal offset register SHALL count 0..NUM_FILAS-1; on fin_fila=1 with modo_fijo=0 it increments, wrapping NUM_FILAS-1 -> 0.
REQ-016 With modo_fijo=1 the offset register SHALL hold (fin_fila ignored); on return to modo_fijo=0 rotation resumes from the held value.
REQ-017 Effective offset E SHALL be desplazamiento_fijo when modo_fijo=1, else the internal offset; desplazamiento_fijo >= NUM_FILAS SHALL be treated as 0.
REQ-018 On a cycle with valido_entrada=1, channel k of salidas SHALL be loaded with channel (k+E) mod NUM_FILAS of entradas; latency exactly 1 cycle.
REQ-019 valido_salida SHALL be valido_entrada delayed one cycle.
REQ-020 With valido_entrada=0, salidas SHALL hold their last value.
REQ-021 Simultaneous valido_entrada=1 and fin_fila=1: data SHALL use the pre-increment offset; new offset applies from the next cycle.
REQ-022 desplazamiento SHALL reflect the offset register directly (registered, no extra latency).
REQ-023 No back-pressure: block accepts every valid word; no ready signal.

Reset
REQ-024 reset=1 at a clock edge SHALL set offset to 0, salidas to all zeros, valido_salida to 0; reset has priority over fin_fila and valido_entrada.
REQ-025 Reset asserted mid-row SHALL discard the in-flight word; first valid word after reset deasserts uses offset 0.

Structure
REQ-026 Shared package filtros_pkg SHALL hold default BITS_DATOS, default NUM_FILAS, and the clog2 constant function.
REQ-027 The wrap-around offset register SHALL be a sub-module contador_modulo (parameters MODULO, ANCHO; ports clk, reset, habilitar, cuenta).
REQ-028 The rotation SHALL be a combinational index selection feeding one output register bank; no additional pipeline stages.

Verification (NUM_FILAS=3, BITS_DATOS=8, channels 0/1/2 = 0x11/0x22/0x33)
REQ-029 Reset, then valido_entrada=1, modo_fijo=0 -> next cycle salidas ch0/1/2 = 0x11/0x22/0x33, valido_salida=1, desplazamiento=0.
REQ-030 Three fin_fila pulses, valid data after each -> offsets 1,2,0; after first pulse salidas = 0x22/0x33/0x11, after second 0x33/0x11/0x22, after third 0x11/0x22/0x33.
REQ-031 valido_entrada=1 and fin_fila=1 same cycle at offset 0 -> output uses offset 0 (0x11/0x22/0x33); desplazamiento=1 next cycle.
REQ-032 modo_fijo=1, desplazamiento_fijo=2, fin_fila pulsed twice -> salidas 0x33/0x11/0x22, desplazamiento unchanged; desplazamiento_fijo=3 -> treated as 0.
REQ-033 valido_entrada dropped for 4 cycles while entradas change -> salidas hold, valido_salida=0 from one cycle after drop.
REQ-034 Reset at offset 2 with valid data in flight -> next cycle salidas=0, valido_salida=0, desplazamiento=0.
